ccc_cart_loader: RTL and testbench

- Sits between the HPS download stream and the po8 core's cartridge port.
- Captures a .CCC image (menu index F1) into a 16 KB cart RAM through a registered write port, and tracks image size.
- Maps CPU cartridge-window addresses onto the loaded image with power-of-two mirroring.
- Drives the CART autostart line as a square wave once an image is valid.

---
 rtl/ccc_cart_loader.sv | 162 ++++++++++++++++
 tb/tb_ccc_cart_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccc_cart_loader.sv
// Cartridge download capture for the po8 core: writes a .CCC image into cart RAM,
// tracks its size, mirrors CPU cartridge-window reads and drives the CART line.
module ccc_cart_loader #(
    parameter logic [7:0] CART_INDEX = 8'd1,
    parameter int         SETTLE_CYC = 16,
    parameter int         CART_DIV   = 28
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        cart_we,
    output logic [13:0] cart_waddr,
    output logic [7:0]  cart_wdata,
    input  logic [13:0] cpu_addr,
    output logic [13:0] cart_raddr,
    output logic [14:0] cart_size,
    output logic        cart_valid,
    output logic        cart_overflow,
    output logic        cart_n
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int DW = $clog2(CART_DIV + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(CART_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SETTLE, ST_READY} state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] settle_cnt_reg;
    logic [DW-1:0] div_reg;
    logic          cart_we_reg, cart_valid_reg, cart_overflow_reg, cart_n_reg;
    logic [13:0]   cart_waddr_reg, mask_reg;
    logic [7:0]    cart_wdata_reg;
    logic [14:0]   cart_size_reg;

    logic          sel, enter_load, settle_done, byte_ok, byte_ovf;
    logic [14:0]   addr_plus1;
    logic [13:0]   size_m1, smear, mask_calc;

    assign sel        = ioctl_download && (ioctl_index == CART_INDEX);
    assign addr_plus1 = {1'b0, ioctl_addr[13:0]} + 15'd1;

    // 14-bit size-1 maps 16384 to 0x3FFF; smearing below the top set bit yields 2^k-1.
    assign size_m1 = cart_size_reg[13:0] - 14'd1;
    generate
        for (genvar gi = 0; gi < 14; gi++) begin : g_smear
            assign smear[gi] = |size_m1[13:gi];
        end
    endgenerate
    assign mask_calc = smear | 14'h03FF;

    always_comb begin
        state_next  = state_reg;
        enter_load  = 1'b0;
        settle_done = 1'b0;
        byte_ok     = 1'b0;
        byte_ovf    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_READY: begin
                if (sel) begin
                    state_next = ST_LOAD;
                    enter_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!sel) begin
                    state_next = ST_SETTLE;
                end else if (ioctl_wr) begin
                    byte_ok  = (ioctl_addr[15:14] == 2'b00);
                    byte_ovf = (ioctl_addr[15:14] != 2'b00);
                end
            end
            ST_SETTLE: begin
                if (sel) begin
                    state_next = ST_LOAD;
                    enter_load = 1'b1;
                end else if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next  = ST_READY;
                    settle_done = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Held at zero outside SETTLE, so every exit from LOAD restarts the count.
    always_ff @(posedge clk_sys) begin
        if (reset || state_reg != ST_SETTLE) begin
            settle_cnt_reg <= '0;
        end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cart_we_reg       <= 1'b0;
            cart_waddr_reg    <= '0;
            cart_wdata_reg    <= '0;
            cart_size_reg     <= '0;
            cart_valid_reg    <= 1'b0;
            cart_overflow_reg <= 1'b0;
            mask_reg          <= 14'h3FFF;
        end else begin
            cart_we_reg <= byte_ok;
            if (byte_ok) begin
                cart_waddr_reg <= ioctl_addr[13:0];
                cart_wdata_reg <= ioctl_data;
                if (addr_plus1 > cart_size_reg) begin
                    cart_size_reg <= addr_plus1;
                end
            end
            if (byte_ovf) begin
                cart_overflow_reg <= 1'b1;
            end
            if (enter_load) begin
                cart_size_reg     <= '0;
                cart_overflow_reg <= 1'b0;
                cart_valid_reg    <= 1'b0;
            end
            if (settle_done) begin
                cart_valid_reg <= (cart_size_reg != 15'd0);
                mask_reg       <= mask_calc;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || enter_load || !cart_valid_reg) begin
            div_reg    <= '0;
            cart_n_reg <= 1'b1;
        end else if (div_reg == DIV_LAST) begin
            div_reg    <= '0;
            cart_n_reg <= ~cart_n_reg;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign cart_we       = cart_we_reg;
    assign cart_waddr    = cart_waddr_reg;
    assign cart_wdata    = cart_wdata_reg;
    assign cart_size     = cart_size_reg;
    assign cart_valid    = cart_valid_reg;
    assign cart_overflow = cart_overflow_reg;
    assign cart_n        = cart_n_reg;
    assign cart_raddr    = cart_valid_reg ? (cpu_addr & mask_reg) : cpu_addr;

endmodule

// File: tb/tb_ccc_cart_loader.sv
// Bench for ccc_cart_loader: image-size table plus write-port scoreboard and
// hand-written sequences for re-download, mid-load reset and strobe corner cases.
module tb_ccc_cart_loader;

    localparam int SETTLE_CYC = 16;
    localparam int CART_DIV   = 28;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        cart_we;
    logic [13:0] cart_waddr;
    logic [7:0]  cart_wdata;
    logic [13:0] cpu_addr;
    logic [14:0] cart_raddr;
    logic [14:0] cart_size;
    logic        cart_valid;
    logic        cart_overflow;
    logic        cart_n;
    logic [13:0] raddr14;

    ccc_cart_loader #(.CART_INDEX(8'd1), .SETTLE_CYC(SETTLE_CYC), .CART_DIV(CART_DIV)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .cart_we(cart_we), .cart_waddr(cart_waddr), .cart_wdata(cart_wdata),
        .cpu_addr(cpu_addr), .cart_raddr(raddr14), .cart_size(cart_size),
        .cart_valid(cart_valid), .cart_overflow(cart_overflow), .cart_n(cart_n)
    );
    assign cart_raddr = {1'b0, raddr14};

    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        int          stamp;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int          nbytes;
        logic [13:0] cpu;
        logic [14:0] exp_size;
        logic        exp_ovf;
        logic        exp_valid;
        logic [13:0] exp_raddr;
    } vec_t;
    vec_t vecs[8];

    // Write-port scoreboard: each accepted strobe must appear exactly one cycle later.
    bit          mon_exp_we;
    logic [13:0] mon_addr;
    logic [7:0]  mon_data;
    always @(negedge clk_sys) begin
        while (exp_q.size() > 0 && exp_q[0].stamp < cyc - 1) begin
            tests++;
            fails++;
            $display("FAIL wr_late: no cart_we for addr %h, required one cycle after strobe", exp_q[0].addr);
            exp_q.delete(0);
        end
        mon_exp_we = (exp_q.size() > 0 && exp_q[0].stamp == cyc - 1);
        mon_addr   = mon_exp_we ? exp_q[0].addr : 14'h0;
        mon_data   = mon_exp_we ? exp_q[0].data : 8'h0;
        if (mon_exp_we || cart_we) begin
            tests++;
            if (cart_we !== mon_exp_we ||
                (mon_exp_we && (cart_waddr !== mon_addr || cart_wdata !== mon_data))) begin
                fails++;
                $display("FAIL wr_port: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                         cart_we, cart_waddr, cart_wdata, mon_exp_we, mon_addr, mon_data);
            end
            if (mon_exp_we) exp_q.delete(0);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] a, input logic [7:0] d, input bit expect_wr);
        wr_t e;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        if (expect_wr) begin
            e.addr  = a[13:0];
            e.data  = d;
            e.stamp = cyc;
            exp_q.push_back(e);
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    // Drops sel and checks that cart_valid appears exactly SETTLE_CYC+1 cycles later.
    task automatic settle_check(input logic exp_valid);
        bit early = 0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        for (int k = 1; k <= SETTLE_CYC; k++) begin
            tick();
            if (cart_valid) early = 1;
        end
        check("valid_early", 32'(early), 32'd0);
        tick();
        check("valid_rise", 32'(cart_valid), 32'(exp_valid));
    endtask

    task automatic wait_cart_n(input logic target, output int n);
        n = 0;
        while (cart_n !== target && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int   n;
        bit   seen;
        logic [7:0] idx;

        vecs[0] = '{8192,  14'h2005, 15'd8192,  1'b0, 1'b1, 14'h0005};
        vecs[1] = '{2049,  14'h3ABC, 15'd2049,  1'b0, 1'b1, 14'h0ABC};
        vecs[2] = '{100,   14'h3ABC, 15'd100,   1'b0, 1'b1, 14'h02BC};
        vecs[3] = '{0,     14'h3ABC, 15'd0,     1'b0, 1'b0, 14'h3ABC};
        vecs[4] = '{16400, 14'h3ABC, 15'd16384, 1'b1, 1'b1, 14'h3ABC};
        vecs[5] = '{4097,  14'h3ABC, 15'd4097,  1'b0, 1'b1, 14'h1ABC};
        vecs[6] = '{1024,  14'h1555, 15'd1024,  1'b0, 1'b1, 14'h0155};
        vecs[7] = '{1025,  14'h1555, 15'd1025,  1'b0, 1'b1, 14'h0555};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = 16'd0; ioctl_data = 8'd0; cpu_addr = 14'h2A5A;
        repeat (3) tick();
        check("rst_we", 32'(cart_we), 32'd0);
        check("rst_waddr", 32'(cart_waddr), 32'd0);
        check("rst_wdata", 32'(cart_wdata), 32'd0);
        check("rst_size", 32'(cart_size), 32'd0);
        check("rst_valid", 32'(cart_valid), 32'd0);
        check("rst_ovf", 32'(cart_overflow), 32'd0);
        check("rst_cart_n", 32'(cart_n), 32'd1);
        check("rst_raddr", cart_raddr, 32'h2A5A);
        reset = 1'b0;

        // Foreign-index traffic must never reach the cart RAM port.
        for (int i = 0; i < 100; i++) begin
            idx = 8'($urandom_range(0, 254));
            if (idx >= 8'd1) idx = idx + 8'd1;
            ioctl_index    = idx;
            ioctl_download = 1'($urandom_range(0, 1));
            ioctl_wr       = 1'($urandom_range(0, 1));
            ioctl_addr     = 16'($urandom);
            ioctl_data     = 8'($urandom);
            tick();
        end
        ioctl_download = 1'b0; ioctl_wr = 1'b0;
        tick();
        check("noise_size", 32'(cart_size), 32'd0);
        check("noise_valid", 32'(cart_valid), 32'd0);

        for (int r = 0; r < 8; r++) begin
            ioctl_index    = 8'd1;
            ioctl_download = 1'b1;
            tick();
            for (int i = 0; i < vecs[r].nbytes; i++)
                strobe(16'(i), 8'(i) ^ 8'(r * 37), i < 16384);
            settle_check(vecs[r].exp_valid);
            cpu_addr = vecs[r].cpu;
            #1;
            check($sformatf("v%0d_size", r), 32'(cart_size), 32'(vecs[r].exp_size));
            check($sformatf("v%0d_ovf", r), 32'(cart_overflow), 32'(vecs[r].exp_ovf));
            check($sformatf("v%0d_raddr", r), cart_raddr, 32'(vecs[r].exp_raddr));
            check($sformatf("v%0d_cart_n", r), 32'(cart_n), 32'd1);
            if (vecs[r].exp_valid) begin
                wait_cart_n(1'b0, n);
                check($sformatf("v%0d_cart_fall", r), 32'(n), 32'(CART_DIV));
                wait_cart_n(1'b1, n);
                check($sformatf("v%0d_cart_rise", r), 32'(n), 32'(CART_DIV));
            end
        end

        // Non-cart index download leaves the loaded image untouched.
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) strobe(16'(i), 8'hC3, 1'b0);
        ioctl_download = 1'b0;
        repeat (20) tick();
        check("idx0_valid", 32'(cart_valid), 32'd1);
        check("idx0_size", 32'(cart_size), 32'd1025);

        // New download while cart_n is low: drops valid and restores cart_n next cycle.
        wait_cart_n(1'b0, n);
        check("pre_redl_cart_n", 32'(cart_n), 32'd0);
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        tick();
        check("redl_valid", 32'(cart_valid), 32'd0);
        check("redl_cart_n", 32'(cart_n), 32'd1);
        check("redl_size", 32'(cart_size), 32'd0);
        for (int i = 0; i < 500; i++) strobe(16'(i), 8'(i * 3), 1'b1);
        reset = 1'b1; ioctl_download = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cart_valid) seen = 1;
        end
        check("midrst_valid", 32'(seen), 32'd0);
        check("midrst_size", 32'(cart_size), 32'd0);

        // Strobe coincident with sel rising is dropped; later writes out of order.
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        ioctl_wr = 1'b1; ioctl_addr = 16'h0500; ioctl_data = 8'hAA;
        tick();
        ioctl_wr = 1'b0;
        strobe(16'd300, 8'h11, 1'b1);
        strobe(16'd10,  8'h22, 1'b1);
        strobe(16'd299, 8'h33, 1'b1);
        check("ooo_size", 32'(cart_size), 32'd301);
        ioctl_download = 1'b0;
        repeat (10) tick();
        check("settle_abort_valid", 32'(cart_valid), 32'd0);
        ioctl_download = 1'b1;
        tick();
        check("reload_size", 32'(cart_size), 32'd0);
        strobe(16'd7, 8'h5E, 1'b1);
        settle_check(1'b1);
        cpu_addr = 14'h3ABC;
        #1;
        check("small_size", 32'(cart_size), 32'd8);
        check("small_raddr", cart_raddr, 32'h02BC);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
